// File: rtl/core_pkg.sv
// Shared types and constants for the 3-stage (IF, EX, WB) RV32I pipeline controller.
// The optional performance counters are enabled with the PIPE_CTRL_PERF_EN macro.
package core_pkg;

    localparam int          XLEN = 32;
    localparam logic [31:0] NOP  = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } pipe_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic            valid;
    } if_ex_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] wdata;
        logic [4:0]      rd;
        logic            rf_en;
        logic            mem_rd;
        logic            mem_wr;
        logic            valid;
    } ex_wb_t;

    localparam if_ex_t IF_EX_RST = '{pc: '0, inst: NOP, valid: 1'b0};
    localparam ex_wb_t EX_WB_RST = '0;

    // A flushed IF/EX slot keeps the fetched PC but carries a bubble.
    function automatic if_ex_t if_ex_bubble(input logic [XLEN-1:0] pc);
        return '{pc: pc, inst: NOP, valid: 1'b0};
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bus between the pipeline controller and the surrounding core (fetch, EX, hazard unit, dmem).
// The perf counter signals exist only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if;
    import core_pkg::*;

    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_inst;
    logic            flush;
    logic [XLEN-1:0] ex_alu;
    logic [XLEN-1:0] ex_wdata;
    logic [4:0]      ex_rd;
    logic            ex_rf_en;
    logic            ex_mem_rd;
    logic            ex_mem_wr;
    logic            dmem_ready;

    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_inst;
    logic [XLEN-1:0] wb_pc;
    logic [XLEN-1:0] wb_alu;
    logic [XLEN-1:0] wb_wdata;
    logic [4:0]      wb_rd;
    logic            wb_rf_en;
    logic            dmem_req;
    logic            dmem_we;
    logic            stall;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]     perf_stall_cnt;
    logic [31:0]     perf_flush_cnt;

    modport master (
        output if_pc, if_inst, flush, ex_alu, ex_wdata, ex_rd, ex_rf_en,
               ex_mem_rd, ex_mem_wr, dmem_ready,
        input  id_pc, id_inst, wb_pc, wb_alu, wb_wdata, wb_rd, wb_rf_en,
               dmem_req, dmem_we, stall, perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  if_pc, if_inst, flush, ex_alu, ex_wdata, ex_rd, ex_rf_en,
               ex_mem_rd, ex_mem_wr, dmem_ready,
        output id_pc, id_inst, wb_pc, wb_alu, wb_wdata, wb_rd, wb_rf_en,
               dmem_req, dmem_we, stall, perf_stall_cnt, perf_flush_cnt
    );
`else
    modport master (
        output if_pc, if_inst, flush, ex_alu, ex_wdata, ex_rd, ex_rf_en,
               ex_mem_rd, ex_mem_wr, dmem_ready,
        input  id_pc, id_inst, wb_pc, wb_alu, wb_wdata, wb_rd, wb_rf_en,
               dmem_req, dmem_we, stall
    );

    modport slave (
        input  if_pc, if_inst, flush, ex_alu, ex_wdata, ex_rd, ex_rf_en,
               ex_mem_rd, ex_mem_wr, dmem_ready,
        output id_pc, id_inst, wb_pc, wb_alu, wb_wdata, wb_rd, wb_rf_en,
               dmem_req, dmem_we, stall
    );
`endif

endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline register: holds when en=0, loads flush_d instead of d when flush=1.
module pipe_reg #(
    parameter type T       = logic,
    parameter T    RST_VAL = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic flush,
    input  T     d,
    input  T     flush_d,
    output T     q
);

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples pre-edge values regardless of the order blocks are evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= flush ? flush_d : d;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// IF/EX and EX/WB pipeline registers, flush handling and the WB data-memory stall FSM.
// Define PIPE_CTRL_PERF_EN to add saturating stall/flush performance counters.
module pipe_ctrl
    import core_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    pipe_ctrl_if.slave   bus
);

    if_ex_t      id_d;
    if_ex_t      id_flush_d;
    if_ex_t      id_q;
    ex_wb_t      wb_d;
    ex_wb_t      wb_q;
    pipe_state_e state;
    logic        stall;
    logic        advance;
    logic        dmem_req;

    // A zero-wait memory completes in the request cycle, so stall is purely combinational.
    assign dmem_req = wb_q.valid & (wb_q.mem_rd | wb_q.mem_wr);
    assign stall    = dmem_req & ~bus.dmem_ready;
    assign advance  = ~stall;

    assign id_d       = '{pc: bus.if_pc, inst: bus.if_inst, valid: 1'b1};
    assign id_flush_d = if_ex_bubble(bus.if_pc);

    // The branch/jump sitting in EX is never flushed; only the younger IF slot is.
    assign wb_d = '{
        pc:     id_q.pc,
        alu:    bus.ex_alu,
        wdata:  bus.ex_wdata,
        rd:     bus.ex_rd,
        rf_en:  bus.ex_rf_en,
        mem_rd: bus.ex_mem_rd,
        mem_wr: bus.ex_mem_wr,
        valid:  id_q.valid
    };

    pipe_reg #(.T(if_ex_t), .RST_VAL(IF_EX_RST)) u_if_ex (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (advance),
        .flush   (bus.flush),
        .d       (id_d),
        .flush_d (id_flush_d),
        .q       (id_q)
    );

    pipe_reg #(.T(ex_wb_t), .RST_VAL(EX_WB_RST)) u_ex_wb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (advance),
        .flush   (1'b0),
        .d       (wb_d),
        .flush_d (EX_WB_RST),
        .q       (wb_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:      if (stall)          state <= MEM_WAIT;
                MEM_WAIT: if (bus.dmem_ready) state <= RUN;
            endcase
        end
    end

    assign bus.id_pc    = id_q.pc;
    assign bus.id_inst  = id_q.inst;
    assign bus.wb_pc    = wb_q.pc;
    assign bus.wb_alu   = wb_q.alu;
    assign bus.wb_wdata = wb_q.wdata;
    // Bubbles report rd=0 so the hazard unit never forwards from them.
    assign bus.wb_rd    = wb_q.valid ? wb_q.rd : 5'd0;
    // Writes land once, on the completing cycle of a load.
    assign bus.wb_rf_en = wb_q.rf_en & wb_q.valid & ~stall;
    assign bus.dmem_req = dmem_req;
    assign bus.dmem_we  = wb_q.valid & wb_q.mem_wr;
    assign bus.stall    = stall;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (advance && bus.flush && flush_cnt != 32'hFFFF_FFFF) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

    assign bus.perf_stall_cnt = stall_cnt;
    assign bus.perf_flush_cnt = flush_cnt;
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline-register and stall controller for the 3-stage (IF, EX, WB) RV32I core. It owns the IF/EX and EX/WB registers and acts on the flush that the hazard unit produces. It also supplies the rd/rf_en that the hazard unit consumes. It sequences data-memory accesses made in WB through a req/ready handshake, freezing the pipe while memory is busy.

Parameters:
XLEN, 32, datapath width
NOP, 32'h00000013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
if_pc  in  XLEN  PC of fetched instruction
if_inst  in  32  fetched instruction
flush  in  1  from hazard unit; branch/jump taken in EX
ex_alu  in  XLEN  EX ALU result
ex_wdata  in  XLEN  store data from EX
ex_rd  in  5  EX destination register
ex_rf_en  in  1  EX writes register file
ex_mem_rd  in  1  EX instruction is a load
ex_mem_wr  in  1  EX instruction is a store
dmem_ready  in  1  data memory completes the access this cycle
id_pc  out  XLEN  IF/EX register PC
id_inst  out  32  IF/EX register instruction
wb_pc  out  XLEN  EX/WB register PC
wb_alu  out  XLEN  EX/WB register ALU result
wb_wdata  out  XLEN  EX/WB register store data
wb_rd  out  5  EX/WB destination register (to hazard unit)
wb_rf_en  out  1  register-file write enable (to hazard unit and RF)
dmem_req  out  1  memory access request
dmem_we  out  1  access is a store
stall  out  1  freeze PC and both pipeline registers

Behaviour:
- Reset (async, rst_n=0):
  - id_inst=NOP, id_pc=0, id_valid=0.
  - All wb_* outputs 0; wb_valid=0.
  - FSM=RUN; stall=0; dmem_req=0.
- EX/WB memory flags: wb_mem_rd and wb_mem_wr are latched from ex_mem_rd and ex_mem_wr.
- dmem_req = wb_valid & (wb_mem_rd | wb_mem_wr). This is combinational from the registers. dmem_we = wb_valid & wb_mem_wr.
- FSM states: RUN, MEM_WAIT.
  - RUN: if dmem_req & !dmem_ready, go to MEM_WAIT. Otherwise stay in RUN.
  - MEM_WAIT: if dmem_ready, go to RUN. Otherwise stay in MEM_WAIT.
- stall = dmem_req & !dmem_ready, in either state. This is combinational, so a zero-wait memory never stalls.
- Register update when stall=0 (every rising edge):
  - IF/EX: if flush, load id_inst=NOP, id_valid=0, id_pc=if_pc. Otherwise load id_inst=if_inst, id_pc=if_pc, id_valid=1.
  - EX/WB: load wb_* from ex_*, with wb_valid=id_valid.
  - The branch/jump in EX itself is never flushed; it advances normally.
- Register update when stall=1: both registers hold their values. flush is ignored because the EX instruction is frozen and re-asserts flush on release. PC redirect is the PC block's responsibility and is gated by stall.
- wb_rf_en = registered rf_en & wb_valid & !stall. The write occurs exactly once, on the completing cycle. For loads, that is the cycle where dmem_ready=1.
- wb_rd is forced to 0 when wb_valid=0, so bubbles cannot trigger forwarding.
- dmem_ready while dmem_req=0 is ignored.
- Simultaneous flush and a completing mem access: the flush is applied, and the registers advance normally.
- Reset mid-MEM_WAIT: returns to RUN; the pending access is abandoned and dmem_req drops immediately.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined, adds outputs perf_stall_cnt (32) and perf_flush_cnt (32).
  - perf_stall_cnt increments every cycle stall=1.
  - perf_flush_cnt increments every unstalled cycle with flush=1.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- When undefined, those ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package core_pkg:
  - XLEN and NOP constants.
  - pipe_state_e enum {RUN, MEM_WAIT}.
  - Packed structs if_ex_t {pc, inst, valid} and ex_wb_t {pc, alu, wdata, rd, rf_en, mem_rd, mem_wr, valid}.
- One natural sub-module: pipe_reg, a generic enable/flush register parameterised by struct type. It is instantiated twice.

Test Plan:
- Reset: hold rst_n=0 mid-stream, then release. Required: id_inst=32'h00000013, wb_rf_en=0, dmem_req=0, stall=0 before the first edge.
- Flush: present if_inst=32'h00500093 with flush=1. Next cycle: id_inst=NOP, id_valid=0. The following cycle: wb_rf_en=0 and wb_rd=0.
- Zero-wait load: ex_mem_rd=1, ex_rd=5, with dmem_ready=1 in the WB cycle. Required: stall never asserts; wb_rf_en=1 and wb_rd=5 for one cycle.
- Wait-state load: same load with dmem_ready low for 3 cycles. Required: stall=1 for 3 cycles, FSM in MEM_WAIT, id/wb registers constant, wb_rf_en=0. On the 4th cycle: ready=1, wb_rf_en=1 once, return to RUN.
- Flush during stall: flush=1 while stall=1. Required: id_inst unchanged during the stall; NOP loaded on the first unstalled edge.
- With PIPE_CTRL_PERF_EN defined: the wait-state load plus 2 flushes give perf_stall_cnt=3 and perf_flush_cnt=2.
